// File: rtl/alu_ctrl_mdu_pkg.sv
// alu_ctrl_mdu_pkg: ALUop/funct/ALUctrl encodings, FSM states and the op decoder.
package alu_ctrl_mdu_pkg;
  typedef enum logic [3:0] {
    CTRL_AND  = 4'b0000,
    CTRL_OR   = 4'b0001,
    CTRL_ADD  = 4'b0010,
    CTRL_SUB  = 4'b0110,
    CTRL_SLT  = 4'b0111,
    CTRL_SLL  = 4'b1000,
    CTRL_SRL  = 4'b1001,
    CTRL_MUL  = 4'b1010,
    CTRL_MULU = 4'b1011,
    CTRL_NOR  = 4'b1100,
    CTRL_MFHI = 4'b1101,
    CTRL_MFLO = 4'b1110,
    CTRL_NOP  = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_e;

  localparam logic [1:0] OP_MEM   = 2'b00;
  localparam logic [1:0] OP_BEQ   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  // NOP is only ever produced for undecodable ops, so it doubles as the illegal flag.
  function automatic alu_ctrl_e decode(input logic [1:0] op, input logic [5:0] fn, input logic en_mul);
    alu_ctrl_e c;
    case (op)
      OP_MEM: c = CTRL_ADD;
      OP_BEQ: c = CTRL_SUB;
      OP_RTYPE:
        case (fn)
          F_ADD:   c = CTRL_ADD;
          F_SUB:   c = CTRL_SUB;
          F_AND:   c = CTRL_AND;
          F_OR:    c = CTRL_OR;
          F_NOR:   c = CTRL_NOR;
          F_SLT:   c = CTRL_SLT;
          F_SLL:   c = CTRL_SLL;
          F_SRL:   c = CTRL_SRL;
          F_MULT:  c = en_mul ? CTRL_MUL : CTRL_NOP;
          F_MULTU: c = en_mul ? CTRL_MULU : CTRL_NOP;
          F_MFHI:  c = en_mul ? CTRL_MFHI : CTRL_NOP;
          F_MFLO:  c = en_mul ? CTRL_MFLO : CTRL_NOP;
          default: c = CTRL_NOP;
        endcase
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// alu_ctrl_mdu_if: issue/result handshake bundle between the EX stage and the ALU/MDU.
interface alu_ctrl_mdu_if #(parameter int WIDTH = 32);
  localparam int SHAMT_W = $clog2(WIDTH);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         ALUop;
  logic [5:0]         funct;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               illegal;
  logic [3:0]         ALUctrl;
  logic               busy;
  modport master (
    output in_valid, ALUop, funct, a, b, shamt,
    input  in_ready, out_valid, result, zero, illegal, ALUctrl, busy
  );
  modport slave (
    input  in_valid, ALUop, funct, a, b, shamt,
    output in_ready, out_valid, result, zero, illegal, ALUctrl, busy
  );
endinterface

// File: rtl/alu_ctrl_mdu_mul_iter.sv
// alu_ctrl_mdu_mul_iter: shift-add unsigned multiplier; bit 0 is folded into the load
// so done rises WIDTH-1 cycles after start with the full product already settled.
module alu_ctrl_mdu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;
  assign done    = run_q && cnt_q == '0;
  assign product = acc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= a[0] ? {{WIDTH{1'b0}}, b} : '0;
      mcand_q  <= {{(WIDTH-1){1'b0}}, b, 1'b0};
      mplier_q <= a >> 1;
      cnt_q    <= CW'(WIDTH - 1);
      run_q    <= 1'b1;
    end else if (done) begin
      run_q <= 1'b0;
    end else if (run_q) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: EX-stage ALU control decode, single-cycle ALU, and iterative MULT/MULTU
// with HI/LO; in_ready drops while a multiply is in flight.
module alu_ctrl_mdu
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit ENABLE_MUL = 1
) (
  input logic            clk,
  input logic            rst,
  alu_ctrl_mdu_if.slave  bus
);
  state_e             state_q;
  logic               out_valid_q, zero_q, illegal_q, neg_q;
  logic [WIDTH-1:0]   result_q, hi_q, lo_q;
  alu_ctrl_e          ctrl_q, ctrl;
  logic [WIDTH-1:0]   alu_res, a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_prod, prod_fix;
  logic               accept, is_mul, signed_mul, mul_start, mul_done;
  assign accept     = bus.in_valid && state_q == S_IDLE;
  assign ctrl       = decode(bus.ALUop, bus.funct, ENABLE_MUL);
  assign is_mul     = ctrl == CTRL_MUL || ctrl == CTRL_MULU;
  assign signed_mul = ctrl == CTRL_MUL;
  assign mul_start  = accept && is_mul;
  // Magnitudes are treated as unsigned, so -2^(WIDTH-1) maps exactly onto 2^(WIDTH-1).
  assign a_mag      = (signed_mul && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag      = (signed_mul && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign prod_fix   = neg_q ? -mul_prod : mul_prod;
  always_comb begin
    alu_res = '0;
    case (ctrl)
      CTRL_AND:  alu_res = bus.a & bus.b;
      CTRL_OR:   alu_res = bus.a | bus.b;
      CTRL_NOR:  alu_res = ~(bus.a | bus.b);
      CTRL_ADD:  alu_res = bus.a + bus.b;
      CTRL_SUB:  alu_res = bus.a - bus.b;
      CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      CTRL_SLL:  alu_res = bus.b << bus.shamt;
      CTRL_SRL:  alu_res = bus.b >> bus.shamt;
      CTRL_MFHI: alu_res = hi_q;
      CTRL_MFLO: alu_res = lo_q;
      default:   alu_res = '0;
    endcase
  end
  if (ENABLE_MUL) begin : g_mul
    alu_ctrl_mdu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a_mag),
      .b       (b_mag),
      .done    (mul_done),
      .product (mul_prod)
    );
  end else begin : g_no_mul
    logic unused_mul;
    assign unused_mul = ^{mul_start, a_mag, b_mag};
    assign mul_done   = 1'b0;
    assign mul_prod   = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      neg_q       <= 1'b0;
      ctrl_q      <= CTRL_NOP;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (accept) begin
            ctrl_q    <= ctrl;
            illegal_q <= ctrl == CTRL_NOP;
            neg_q     <= signed_mul && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            if (is_mul) begin
              state_q <= S_MUL;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= alu_res == '0;
            end
          end
        // The sign-corrected product is registered on the MUL->FIX edge so FIX presents it.
        S_MUL:
          if (mul_done) begin
            state_q     <= S_FIX;
            out_valid_q <= 1'b1;
            result_q    <= prod_fix[WIDTH-1:0];
            zero_q      <= prod_fix[WIDTH-1:0] == '0;
            hi_q        <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q        <= prod_fix[WIDTH-1:0];
          end
        S_FIX:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.in_ready  = state_q == S_IDLE;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
  assign bus.ALUctrl   = ctrl_q;
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: directed ops with a scoreboard queue checked by a separate monitor,
// plus side instances for WIDTH=8 and ENABLE_MUL=0.
module tb_alu_ctrl_mdu;
  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  ctrl;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  bit   aux_done = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  alu_ctrl_mdu_if #(.WIDTH(32)) bus ();
  alu_ctrl_mdu_if #(.WIDTH(8))  b8 ();
  alu_ctrl_mdu_if #(.WIDTH(32)) bn ();

  alu_ctrl_mdu #(.WIDTH(32), .ENABLE_MUL(1)) dut    (.clk(clk), .rst(rst), .bus(bus.slave));
  alu_ctrl_mdu #(.WIDTH(8),  .ENABLE_MUL(1)) dut_w8 (.clk(clk), .rst(rst), .bus(b8.slave));
  alu_ctrl_mdu #(.WIDTH(32), .ENABLE_MUL(0)) dut_nm (.clk(clk), .rst(rst), .bus(bn.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got === expv) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh,
                       input logic [31:0] er, input logic [3:0] ectrl, input int lat,
                       input bit push, output int waited);
    waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUop    = op;
    bus.funct    = fn;
    bus.a        = av;
    bus.b        = bv;
    bus.shamt    = sh;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      total++;
      $display("FAIL %s accept: got in_ready stuck low, required acceptance", tag);
    end
    if (push) q.push_back('{tag, er, ectrl, cyc + lat});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected out_valid at cycle %0d: got result 0x%0h, required no output", cyc, bus.result);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.tag, " latency"}, 64'(cyc), 64'(mon_e.due));
        check({mon_e.tag, " result"},  bus.result, mon_e.res);
        check({mon_e.tag, " zero"},    bus.zero, mon_e.res == 32'd0);
        check({mon_e.tag, " illegal"}, bus.illegal, mon_e.ctrl == 4'hF);
        check({mon_e.tag, " ALUctrl"}, bus.ALUctrl, mon_e.ctrl);
      end
    end
  end

  initial begin : aux
    int w;
    b8.in_valid = 1'b0; b8.ALUop = 2'b00; b8.funct = 6'd0; b8.a = 8'd0; b8.b = 8'd0; b8.shamt = 3'd0;
    bn.in_valid = 1'b0; bn.ALUop = 2'b00; bn.funct = 6'd0; bn.a = 32'd0; bn.b = 32'd0; bn.shamt = 5'd0;
    wait (!rst);
    @(negedge clk);
    b8.in_valid = 1'b1; b8.ALUop = 2'b10; b8.funct = 6'b011000; b8.a = 8'hFD; b8.b = 8'h07;
    bn.in_valid = 1'b1; bn.ALUop = 2'b10; bn.funct = 6'b011000; bn.a = 32'hFFFF_FFFD; bn.b = 32'd7;
    @(negedge clk);
    b8.in_valid = 1'b0;
    bn.in_valid = 1'b0;
    check("nomul mult out_valid", bn.out_valid, 1'b1);
    check("nomul mult illegal",   bn.illegal, 1'b1);
    check("nomul mult result",    bn.result, 32'd0);
    check("nomul mult ALUctrl",   bn.ALUctrl, 4'hF);
    check("nomul ready",          bn.in_ready, 1'b1);
    w = 1;
    while (!b8.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("w8 mult latency", 64'(w), 64'd9);
    check("w8 mult LO",      b8.result, 8'hEB);
    check("w8 mult ALUctrl", b8.ALUctrl, 4'hA);
    @(negedge clk);
    b8.in_valid = 1'b1; b8.ALUop = 2'b10; b8.funct = 6'b010000;
    @(negedge clk);
    b8.in_valid = 1'b0;
    check("w8 mfhi out_valid", b8.out_valid, 1'b1);
    check("w8 mfhi HI",        b8.result, 8'hFF);
    aux_done = 1'b1;
  end

  initial begin : main
    int w;
    bus.in_valid = 1'b0; bus.ALUop = 2'b00; bus.funct = 6'd0;
    bus.a = 32'd0; bus.b = 32'd0; bus.shamt = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready",  bus.in_ready, 1'b1);
    check("reset busy",      bus.busy, 1'b0);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset result",    bus.result, 32'd0);
    check("reset ALUctrl",   bus.ALUctrl, 4'hF);
    check("reset illegal",   bus.illegal, 1'b0);

    issue("lw_add",   2'b00, 6'b000000, 32'd5,          32'd7,          5'd0,  32'd12,         4'h2, 1, 1, w);
    issue("beq_sub",  2'b01, 6'b000000, 32'd9,          32'd9,          5'd0,  32'd0,          4'h6, 1, 1, w);
    issue("slt",      2'b10, 6'b101010, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1,          4'h7, 1, 1, w);
    issue("nor",      2'b10, 6'b100111, 32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  4'hC, 1, 1, w);
    issue("sll",      2'b10, 6'b000000, 32'd0,          32'd1,          5'd31, 32'h8000_0000,  4'h8, 1, 1, w);
    issue("srl",      2'b10, 6'b000010, 32'd0,          32'h8000_0000,  5'd4,  32'h0800_0000,  4'h9, 1, 1, w);
    issue("and",      2'b10, 6'b100100, 32'h0000_F0F0,  32'h0000_FF00,  5'd0,  32'h0000_F000,  4'h0, 1, 1, w);
    issue("or",       2'b10, 6'b100101, 32'h0000_F0F0,  32'h0000_FF00,  5'd0,  32'h0000_FFF0,  4'h1, 1, 1, w);
    issue("sub_neg",  2'b10, 6'b100010, 32'd3,          32'd5,          5'd0,  32'hFFFF_FFFE,  4'h6, 1, 1, w);
    issue("add_wrap", 2'b10, 6'b100000, 32'hFFFF_FFFF,  32'd2,          5'd0,  32'd1,          4'h2, 1, 1, w);

    issue("mult",     2'b10, 6'b011000, 32'hFFFF_FFFD,  32'd7,          5'd0,  32'hFFFF_FFEB,  4'hA, 33, 1, w);
    issue("mfhi",     2'b10, 6'b010000, 32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  4'hD, 1, 1, w);
    check("mult busy cycles", 64'(w), 64'd33);
    issue("mflo",     2'b10, 6'b010010, 32'd0,          32'd0,          5'd0,  32'hFFFF_FFEB,  4'hE, 1, 1, w);

    issue("multu",    2'b10, 6'b011001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd0,  32'd1,          4'hB, 33, 1, w);
    issue("held_add", 2'b00, 6'b000000, 32'd1,          32'd1,          5'd0,  32'd2,          4'h2, 1, 1, w);
    check("held op wait", 64'(w), 64'd33);
    issue("mfhi_u",   2'b10, 6'b010000, 32'd0,          32'd0,          5'd0,  32'hFFFF_FFFE,  4'hD, 1, 1, w);

    issue("mult_min", 2'b10, 6'b011000, 32'h8000_0000,  32'hFFFF_FFFF,  5'd0,  32'h8000_0000,  4'hA, 33, 1, w);
    issue("mfhi_min", 2'b10, 6'b010000, 32'd0,          32'd0,          5'd0,  32'd0,          4'hD, 1, 1, w);

    issue("ill_funct", 2'b10, 6'b111111, 32'd1,         32'd2,          5'd0,  32'd0,          4'hF, 1, 1, w);
    issue("ill_op",    2'b11, 6'b100000, 32'd1,         32'd2,          5'd0,  32'd0,          4'hF, 1, 1, w);
    issue("mflo_keep", 2'b10, 6'b010010, 32'd0,         32'd0,          5'd0,  32'h8000_0000,  4'hE, 1, 1, w);
    issue("mfhi_keep", 2'b10, 6'b010000, 32'd0,         32'd0,          5'd0,  32'd0,          4'hD, 1, 1, w);

    issue("mult_abort", 2'b10, 6'b011000, 32'd5,        32'd6,          5'd0,  32'd0,          4'h0, 0, 0, w);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready",  bus.in_ready, 1'b1);
    check("abort busy",      bus.busy, 1'b0);
    check("abort out_valid", bus.out_valid, 1'b0);
    check("abort ALUctrl",   bus.ALUctrl, 4'hF);
    repeat (40) @(negedge clk);
    issue("mflo_abort", 2'b10, 6'b010010, 32'd0, 32'd0, 5'd0, 32'd0, 4'hE, 1, 1, w);
    issue("mfhi_abort", 2'b10, 6'b010000, 32'd0, 32'd0, 5'd0, 32'd0, 4'hD, 1, 1, w);

    w = 0;
    while ((q.size() != 0 || !aux_done) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL pending outputs: got %0d missing out_valid pulses, required 0", q.size());
    end
    if (!aux_done) begin
      total++;
      $display("FAIL side instances: got unfinished, required finished");
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
